// File: rtl/kamus_pkg.sv
// rtl/kamus_pkg.sv - shared kamus core types: decoded operations, hazard-sequencer states, trap vector
package kamus_pkg;

  typedef enum logic [4:0] {
    OP_INVALID,
    OP_ADD,
    OP_SUB,
    OP_LW,
    OP_SW,
    OP_BEQ,
    OP_JAL,
    OP_FENCE_I,
    OP_CSRRW,
    OP_CSRRS,
    OP_CSRRC
  } operation_e;

  typedef enum logic [2:0] {
    HZ_RUN,
    HZ_SQUASH,
    HZ_FENCE_DRAIN,
    HZ_FENCE_INV,
    HZ_CSR_DRAIN
  } hz_state_e;

  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  function automatic logic is_csr_op(input operation_e op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

endpackage

// File: rtl/kamus_hazard_ctrl_if.sv
// rtl/kamus_hazard_ctrl_if.sv - pipeline-status inputs and stage-control outputs of the hazard sequencer
interface kamus_hazard_ctrl_if
  import kamus_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int PERF_WIDTH = 32
);

  logic                  id_valid_i;
  operation_e            id_op_i;
  logic [4:0]            id_rs1_addr_i;
  logic [4:0]            id_rs2_addr_i;
  logic [PC_WIDTH-1:0]   id_pc_i;
  logic [PC_WIDTH-1:0]   id_next_pc_i;
  logic                  ex_valid_i;
  logic                  ex_is_load_i;
  logic [4:0]            ex_rd_addr_i;
  logic                  ex_redirect_i;
  logic [PC_WIDTH-1:0]   ex_redirect_pc_i;
  logic                  mem_busy_i;
  logic                  l1i_inv_done_i;

  logic                  if_stall_o;
  logic                  id_stall_o;
  logic                  ex_bubble_o;
  logic                  if_squash_o;
  logic                  pc_redirect_o;
  logic [PC_WIDTH-1:0]   pc_redirect_addr_o;
  logic                  l1i_inv_o;
  logic                  trap_o;
  logic [PC_WIDTH-1:0]   trap_epc_o;
  logic [PERF_WIDTH-1:0] stall_cnt_o;

  modport master (
    output id_valid_i, id_op_i, id_rs1_addr_i, id_rs2_addr_i, id_pc_i, id_next_pc_i,
    output ex_valid_i, ex_is_load_i, ex_rd_addr_i, ex_redirect_i, ex_redirect_pc_i,
    output mem_busy_i, l1i_inv_done_i,
    input  if_stall_o, id_stall_o, ex_bubble_o, if_squash_o, pc_redirect_o,
    input  pc_redirect_addr_o, l1i_inv_o, trap_o, trap_epc_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_op_i, id_rs1_addr_i, id_rs2_addr_i, id_pc_i, id_next_pc_i,
    input  ex_valid_i, ex_is_load_i, ex_rd_addr_i, ex_redirect_i, ex_redirect_pc_i,
    input  mem_busy_i, l1i_inv_done_i,
    output if_stall_o, id_stall_o, ex_bubble_o, if_squash_o, pc_redirect_o,
    output pc_redirect_addr_o, l1i_inv_o, trap_o, trap_epc_o, stall_cnt_o
  );

endinterface

// File: rtl/kamus_sat_counter.sv
// rtl/kamus_sat_counter.sv - saturating up-counter with synchronous clear
module kamus_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/kamus_hazard_ctrl.sv
// rtl/kamus_hazard_ctrl.sv - IF/ID/EX hazard sequencer: load-use bubbles, redirect squash,
// FENCE_I / CSR serialisation and illegal-instruction traps
module kamus_hazard_ctrl
  import kamus_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  SQUASH_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] TRAP_VEC     = PC_WIDTH'(TRAP_VEC_DEFAULT),
  parameter int                  PERF_WIDTH   = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  kamus_hazard_ctrl_if.slave hz
);

  localparam int                CNT_W          = (SQUASH_DEPTH > 1) ? $clog2(SQUASH_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  SQUASH_RELOAD  = CNT_W'(SQUASH_DEPTH - 1);
  localparam hz_state_e         REDIRECT_STATE = (SQUASH_DEPTH > 1) ? HZ_SQUASH : HZ_RUN;

  hz_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_squash_cnt, w_squash_cnt_nxt;
  logic [PC_WIDTH-1:0] r_fence_pc, w_fence_pc_nxt;

  logic                w_load_use, w_illegal, w_fence, w_csr;
  logic                w_hold, w_squash, w_redirect, w_inv, w_trap;
  logic [PC_WIDTH-1:0] w_redirect_addr, w_trap_epc;

  // Conservative: any rs match counts, whether or not the op reads that operand.
  assign w_load_use = hz.ex_valid_i && hz.ex_is_load_i && (hz.ex_rd_addr_i != 5'd0) &&
                      ((hz.ex_rd_addr_i == hz.id_rs1_addr_i) || (hz.ex_rd_addr_i == hz.id_rs2_addr_i)) &&
                      hz.id_valid_i;
  assign w_illegal  = hz.id_valid_i && (hz.id_op_i == OP_INVALID);
  assign w_fence    = hz.id_valid_i && (hz.id_op_i == OP_FENCE_I);
  assign w_csr      = hz.id_valid_i && is_csr_op(hz.id_op_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= HZ_RUN;
      r_squash_cnt <= '0;
      r_fence_pc   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_squash_cnt <= w_squash_cnt_nxt;
      r_fence_pc   <= w_fence_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_squash_cnt_nxt = r_squash_cnt;
    w_fence_pc_nxt   = r_fence_pc;
    w_hold           = 1'b0;
    w_squash         = 1'b0;
    w_redirect       = 1'b0;
    w_redirect_addr  = '0;
    w_inv            = 1'b0;
    w_trap           = 1'b0;
    w_trap_epc       = '0;

    // EX is empty in FENCE_INV, so a redirect there can only be spurious.
    if (hz.ex_redirect_i && (r_state != HZ_FENCE_INV)) begin
      w_redirect       = 1'b1;
      w_redirect_addr  = hz.ex_redirect_pc_i;
      w_squash         = 1'b1;
      w_state_nxt      = REDIRECT_STATE;
      w_squash_cnt_nxt = SQUASH_RELOAD;
    end else begin
      unique case (r_state)
        HZ_RUN: begin
          if (w_illegal) begin
            w_trap           = 1'b1;
            w_trap_epc       = hz.id_pc_i;
            w_redirect       = 1'b1;
            w_redirect_addr  = TRAP_VEC;
            w_squash         = 1'b1;
            w_state_nxt      = REDIRECT_STATE;
            w_squash_cnt_nxt = SQUASH_RELOAD;
          end else if (w_fence) begin
            w_hold         = 1'b1;
            w_fence_pc_nxt = hz.id_next_pc_i;
            w_state_nxt    = HZ_FENCE_DRAIN;
          end else if (w_csr && hz.ex_valid_i) begin
            w_hold      = 1'b1;
            w_state_nxt = HZ_CSR_DRAIN;
          end else if (w_load_use) begin
            w_hold = 1'b1;
          end
        end
        HZ_SQUASH: begin
          w_squash = 1'b1;
          if (r_squash_cnt <= CNT_W'(1)) begin
            w_squash_cnt_nxt = '0;
            w_state_nxt      = HZ_RUN;
          end else begin
            w_squash_cnt_nxt = r_squash_cnt - CNT_W'(1);
          end
        end
        HZ_FENCE_DRAIN: begin
          w_hold = 1'b1;
          if (!hz.ex_valid_i && !hz.mem_busy_i) begin
            w_inv       = 1'b1;
            w_state_nxt = HZ_FENCE_INV;
          end
        end
        HZ_FENCE_INV: begin
          if (hz.l1i_inv_done_i) begin
            w_redirect       = 1'b1;
            w_redirect_addr  = r_fence_pc;
            w_squash         = 1'b1;
            w_state_nxt      = REDIRECT_STATE;
            w_squash_cnt_nxt = SQUASH_RELOAD;
          end else begin
            w_hold = 1'b1;
          end
        end
        HZ_CSR_DRAIN: begin
          if (hz.ex_valid_i) begin
            w_hold = 1'b1;
          end else begin
            w_state_nxt = HZ_RUN;
          end
        end
        default: w_state_nxt = HZ_RUN;
      endcase
    end
  end

  assign hz.if_stall_o         = w_hold;
  assign hz.id_stall_o         = w_hold;
  assign hz.ex_bubble_o        = w_hold | w_squash;
  assign hz.if_squash_o        = w_squash;
  assign hz.pc_redirect_o      = w_redirect;
  assign hz.pc_redirect_addr_o = w_redirect_addr;
  assign hz.l1i_inv_o          = w_inv;
  assign hz.trap_o             = w_trap;
  assign hz.trap_epc_o         = w_trap_epc;

  kamus_sat_counter #(
    .WIDTH(PERF_WIDTH)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (w_hold),
    .cnt_o (hz.stall_cnt_o)
  );

endmodule
